// File: rtl/pow_sequencer.sv
// pow_sequencer: computes A^B (A IEEE-754 single, B unsigned integer) by
// right-to-left square-and-multiply on one shared FP multiplier.
// The multiply start/done handshake, sticky overflow/underflow flags and a
// per-multiply watchdog are owned here.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   start, A, B         operation request (accepted only when idle), base, exponent
//   busy                high whenever an operation is in progress
//   done                one-cycle completion pulse
//   result              A^B, held until the next accepted start
//   overflow/underflow  sticky multiplier flags for the operation
//   timeout             operation aborted by the watchdog
//   mul_start/a/b       one-cycle multiply request, operands held until mul_done
//   mul_done/result     multiplier completion pulse and product
//   mul_overflow/underflow  multiplier flags, valid with mul_done
module pow_sequencer #(
    parameter int unsigned N_WIDTH     = 24,
    parameter int unsigned MUL_TIMEOUT = 255
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [31:0]        A,
    input  logic [N_WIDTH-1:0] B,
    output logic               busy,
    output logic               done,
    output logic [31:0]        result,
    output logic               overflow,
    output logic               underflow,
    output logic               timeout,
    output logic               mul_start,
    output logic [31:0]        mul_a,
    output logic [31:0]        mul_b,
    input  logic               mul_done,
    input  logic [31:0]        mul_result,
    input  logic               mul_overflow,
    input  logic               mul_underflow
);

    localparam int unsigned WD_W    = $clog2(MUL_TIMEOUT + 1);
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_NEXT,
        S_WAIT_ACC,
        S_WAIT_SQ,
        S_FINISH
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          acc_q, acc_d;
    logic [31:0]          base_q, base_d;
    logic [N_WIDTH-1:0]   e_q, e_d;
    logic                 acc_is_one_q, acc_is_one_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 done_q, done_d;
    logic [31:0]          result_q, result_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 timeout_q, timeout_d;
    logic                 mul_start_q, mul_start_d;
    logic [31:0]          mul_a_q, mul_a_d;
    logic [31:0]          mul_b_q, mul_b_d;

    logic [N_WIDTH-1:0]   e_shift;
    logic [WD_W-1:0]      wdog_inc;
    logic                 mul_ok;
    logic                 wd_expired;

    assign e_shift    = e_q >> 1;
    assign wdog_inc   = wdog_q + 1'b1;
    assign wd_expired = (wdog_inc == WD_W'(MUL_TIMEOUT));
    // mul_start is high in the first wait cycle, so a done pulse coincident
    // with the request can never be mistaken for its completion.
    assign mul_ok     = mul_done && !mul_start_q;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        base_d       = base_q;
        e_d          = e_q;
        acc_is_one_d = acc_is_one_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        wdog_d       = wdog_q;
        done_d       = 1'b0;
        result_d     = result_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        timeout_d    = timeout_q;
        mul_start_d  = 1'b0;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d       = A;
                    e_d          = B;
                    acc_d        = FP_ONE;
                    acc_is_one_d = 1'b1;
                    ovf_d        = 1'b0;
                    unf_d        = 1'b0;
                    result_d     = '0;
                    overflow_d   = 1'b0;
                    underflow_d  = 1'b0;
                    timeout_d    = 1'b0;
                    state_d      = (B == '0) ? S_FINISH : S_EVAL;
                end
            end
            S_EVAL: begin
                if (!e_q[0]) begin
                    state_d = S_NEXT;
                end else if (acc_is_one_q) begin
                    // First set bit: 1.0 * base is just base, skip the multiply.
                    acc_d        = base_q;
                    acc_is_one_d = 1'b0;
                    state_d      = S_NEXT;
                end else begin
                    mul_start_d = 1'b1;
                    mul_a_d     = acc_q;
                    mul_b_d     = base_q;
                    wdog_d      = '0;
                    state_d     = S_WAIT_ACC;
                end
            end
            S_WAIT_ACC: begin
                if (mul_ok) begin
                    acc_d   = mul_result;
                    ovf_d   = ovf_q | mul_overflow;
                    unf_d   = unf_q | mul_underflow;
                    state_d = S_NEXT;
                end else begin
                    wdog_d = wdog_inc;
                    if (wd_expired) begin
                        timeout_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end
            end
            S_NEXT: begin
                e_d = e_shift;
                if (e_shift == '0) begin
                    state_d = S_FINISH;
                end else begin
                    mul_start_d = 1'b1;
                    mul_a_d     = base_q;
                    mul_b_d     = base_q;
                    wdog_d      = '0;
                    state_d     = S_WAIT_SQ;
                end
            end
            S_WAIT_SQ: begin
                if (mul_ok) begin
                    base_d  = mul_result;
                    ovf_d   = ovf_q | mul_overflow;
                    unf_d   = unf_q | mul_underflow;
                    state_d = S_EVAL;
                end else begin
                    wdog_d = wdog_inc;
                    if (wd_expired) begin
                        timeout_d = 1'b1;
                        state_d   = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                done_d      = 1'b1;
                result_d    = timeout_q ? FP_QNAN : acc_q;
                overflow_d  = ovf_q;
                underflow_d = unf_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            base_q       <= '0;
            e_q          <= '0;
            acc_is_one_q <= 1'b0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
            wdog_q       <= '0;
            done_q       <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            timeout_q    <= 1'b0;
            mul_start_q  <= 1'b0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            base_q       <= base_d;
            e_q          <= e_d;
            acc_is_one_q <= acc_is_one_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
            wdog_q       <= wdog_d;
            done_q       <= done_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            timeout_q    <= timeout_d;
            mul_start_q  <= mul_start_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign result    = result_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign timeout   = timeout_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: doc/pow_sequencer.md
# pow_sequencer

Sequencer that computes an IEEE-754 single-precision integer power A^B by right-to-left square-and-multiply on one shared floating-point multiplier. It owns the multiplier's start/done handshake, holds the running accumulator and base, accumulates sticky overflow/underflow flags, and guards every multiply with a watchdog. It sits between the calculator's operation front end and the existing FP multiply datapath.

## Interface

Parameters:
- `N_WIDTH`, default 24: width of the unsigned exponent `B`.
- `MUL_TIMEOUT`, default 255: maximum cycles from `mul_start` to `mul_done` before abort.

Ports (one clock `CLK`; `RST` is asynchronous and active-high):
- `CLK` in 1: clock, rising edge.
- `RST` in 1: asynchronous active-high reset.
- `start` in 1: request; accepted only in IDLE.
- `A` in 32: base, IEEE-754 single.
- `B` in N_WIDTH: exponent, unsigned integer.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `result` out 32: A^B, held until the next accepted `start`.
- `overflow` out 1: sticky OR of all multiplier overflow flags for this operation.
- `underflow` out 1: sticky OR of all multiplier underflow flags for this operation.
- `timeout` out 1: operation aborted by the watchdog.
- `mul_start` out 1: one-cycle multiply request.
- `mul_a` out 32, `mul_b` out 32: multiplier operands, held from `mul_start` until `mul_done`.
- `mul_done` in 1: multiplier completion pulse.
- `mul_result` in 32: multiplier product.
- `mul_overflow` in 1, `mul_underflow` in 1: multiplier flags, sampled with `mul_done`.

## Operation

- Internal registers: `acc` (32), `base` (32), `e` (N_WIDTH), `acc_is_one`, sticky `ovf` and `unf`, and a watchdog counter of width clog2(MUL_TIMEOUT+1).
- States and transitions:
  - IDLE: on `start`, latch `base`=A, `e`=B, `acc`=32'h3F800000, `acc_is_one`=1, clear sticky flags and the `result`, `overflow`, `underflow` and `timeout` outputs. If B==0, go to FINISH; otherwise go to EVAL.
  - EVAL, when `e[0]`=1 and `acc_is_one`: set `acc`=`base`, clear `acc_is_one`, go to NEXT. No multiply is issued.
  - EVAL, when `e[0]`=1 and `acc_is_one`=0: issue `acc`×`base`, go to WAIT_ACC.
  - EVAL, when `e[0]`=0: go to NEXT.
  - WAIT_ACC: on `mul_done`, set `acc`=`mul_result`, OR the flags into the sticky flags, go to NEXT.
  - NEXT: shift `e` right by 1. If the shifted value is 0, go to FINISH. Otherwise issue `base`×`base` and go to WAIT_SQ.
  - WAIT_SQ: on `mul_done`, set `base`=`mul_result`, OR the flags into the sticky flags, go to EVAL.
  - FINISH: `done`=1, `result`=`acc`, `overflow`=`ovf`, `underflow`=`unf`; go to IDLE.
- Issuing a multiply: `mul_start`, `mul_a` and `mul_b` are registered. `mul_start` is high for exactly the first cycle of WAIT_ACC or WAIT_SQ.
- Multiply count for B≠0: msb_index(B) squarings plus popcount(B)−1 accumulator multiplies.
- B==0 returns 32'h3F800000 for any A, including NaN and Inf.
- All other special values (NaN, Inf, zero, sign) are left to the multiplier. A negative A with odd B yields a negative result through the multiplier.
- Watchdog: the counter clears on each issue and increments in WAIT_ACC and WAIT_SQ. If it reaches MUL_TIMEOUT without `mul_done`, go to FINISH with `result`=32'h7FC00000 and `timeout`=1.
- `mul_done` is ignored outside WAIT_ACC and WAIT_SQ, including a late pulse after a timeout or after reset.
- `start` is ignored while `busy`=1.

## Timing

- Reset values: `busy`, `done`, `result`, `overflow`, `underflow`, `timeout`, `mul_start`, `mul_a` and `mul_b` are all 0; the state is IDLE.
- Reset is asynchronous. Asserting `RST` mid-operation aborts immediately, with no `done` pulse.
- Call the edge that samples `start` edge 0.
  - `busy` rises after edge 0.
  - B==0: `done` is high in cycle 1, i.e. after edge 1.
  - B==1: states run EVAL, NEXT, FINISH, so `done` is high in cycle 3.
- Each multiply adds L+1 cycles, where L is the number of cycles from `mul_start` to `mul_done` (L≥1).
- `mul_done` in the same cycle as `mul_start` is ignored.
- `busy` falls in the cycle after `done`. A new `start` may be sampled in that first IDLE cycle.

## Test plan

- A=32'h40000000 (2.0), B=10, multiplier latency 3 → exactly 4 `mul_start` pulses; `result`=32'h44800000; `overflow`=0, `underflow`=0, `timeout`=0.
- A=32'h41420000 (12.125), B=3 → 2 multiplies; `result`=32'h44DED210 (1782.564453125).
- B=0 with A=32'h7FC00000 → no `mul_start`; `done` in cycle 1; `result`=32'h3F800000. B=1 with A=32'hC0400000 → `done` in cycle 3, `result`=32'hC0400000.
- A=32'h7F000000, B=2, model raises `mul_overflow` with `mul_result`=32'h7F800000 → `overflow`=1, `result`=32'h7F800000. A subsequent start clears `overflow`.
- Model never asserts `mul_done`, MUL_TIMEOUT=16 → `done` exactly 16 cycles into WAIT_SQ; `result`=32'h7FC00000, `timeout`=1. A late `mul_done` is ignored.
- Assert `RST` during WAIT_SQ → all outputs 0 immediately; `start` is ignored while `busy`; a fresh operation afterwards completes correctly.
